instr_encoder_loader: RTL

//  Inverse of the instruction decode stage: packs field tuples (format, rsrc1, rsrc2, rdst, opcode, imm) into 32-bit words.

---
 rtl/instr_fmt_pkg.sv | 48 ++++
 rtl/instr_word_pack.sv | 74 +++++++
 rtl/instr_encoder_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fmt_pkg.sv
// Shared instruction-format definitions for the encoder/loader: format codes,
// opcode constants, field positions and loader FSM state codes.
package instr_fmt_pkg;

  localparam logic [1:0] FMT_A   = 2'd0;
  localparam logic [1:0] FMT_B   = 2'd1;
  localparam logic [1:0] FMT_C   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  localparam logic [5:0] OPC_NOP = 6'h3F;
  localparam logic [5:0] OPC_B0  = 6'h22;
  localparam logic [5:0] OPC_B1  = 6'h23;

  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int OPC_A_W = 17;
  localparam int OPC_W   = 6;
  localparam int IMM_B_W = 16;
  localparam int IMM_C_W = 26;

  localparam int RS1_LSB  = 27;
  localparam int A_RS2_LSB = 22;
  localparam int A_RD_LSB  = 17;
  localparam int B_RD_LSB  = 22;
  localparam int IMM_LSB   = 6;
  localparam int OPC_LSB   = 0;

  localparam logic [WORD_W-1:0] NOP_WORD = {26'h0000000, OPC_NOP};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]         fmt;
    logic [REG_W-1:0]   rsrc1;
    logic [REG_W-1:0]   rsrc2;
    logic [REG_W-1:0]   rdst;
    logic [OPC_A_W-1:0] opcode;
    logic [IMM_C_W-1:0] imm;
  } instr_fields_t;

  function automatic logic is_b_opcode(input logic [OPC_W-1:0] op);
    return (op == OPC_B0) || (op == OPC_B1);
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: field tuple -> 32-bit instruction word plus legal flag.
// With FIELD_CHECK_EN defined, tuples that would not re-decode to their own format are flagged.
module instr_word_pack
  import instr_fmt_pkg::*;
(
  input  instr_fields_t       fields_i,
  output logic [WORD_W-1:0]   word_o,
  output logic                legal_o
);

  logic [WORD_W-1:0] raw_s;
  logic              fields_ok_s;
  logic              a_ok_s;
  logic              b_ok_s;
  logic              c_ok_s;

`ifdef FIELD_CHECK_EN
  // Decode-stage format selection keys on opcode[5:0], so it must agree with the format.
  assign a_ok_s = (fields_i.opcode[OPC_W-1:0] == 6'h00);
  assign b_ok_s = is_b_opcode(fields_i.opcode[OPC_W-1:0]) &&
                  (fields_i.imm[IMM_C_W-1:IMM_B_W] == 10'h000);
  assign c_ok_s = (fields_i.opcode[OPC_W-1:0] != 6'h00) &&
                  !is_b_opcode(fields_i.opcode[OPC_W-1:0]);
`else
  assign a_ok_s = 1'b1;
  assign b_ok_s = 1'b1;
  assign c_ok_s = 1'b1;
`endif

  // Place fields per format; illegal format always yields a NOP.
  always_comb begin
    raw_s       = NOP_WORD;
    fields_ok_s = 1'b0;
    case (fields_i.fmt)
      FMT_A: begin
        raw_s = {WORD_W{1'b0}};
        raw_s[RS1_LSB   +: REG_W]   = fields_i.rsrc1;
        raw_s[A_RS2_LSB +: REG_W]   = fields_i.rsrc2;
        raw_s[A_RD_LSB  +: REG_W]   = fields_i.rdst;
        raw_s[OPC_LSB   +: OPC_A_W] = fields_i.opcode;
        fields_ok_s = a_ok_s;
      end
      FMT_B: begin
        raw_s = {WORD_W{1'b0}};
        raw_s[RS1_LSB  +: REG_W]   = fields_i.rsrc1;
        raw_s[B_RD_LSB +: REG_W]   = fields_i.rdst;
        raw_s[IMM_LSB  +: IMM_B_W] = fields_i.imm[IMM_B_W-1:0];
        raw_s[OPC_LSB  +: OPC_W]   = fields_i.opcode[OPC_W-1:0];
        fields_ok_s = b_ok_s;
      end
      FMT_C: begin
        raw_s = {WORD_W{1'b0}};
        raw_s[IMM_LSB +: IMM_C_W] = fields_i.imm;
        raw_s[OPC_LSB +: OPC_W]   = fields_i.opcode[OPC_W-1:0];
        fields_ok_s = c_ok_s;
      end
      default: begin
        raw_s       = NOP_WORD;
        fields_ok_s = 1'b0;
      end
    endcase
  end

  // A rejected tuple still occupies its slot, as a NOP.
  always_comb begin
    if (fields_ok_s) begin
      word_o = raw_s;
    end else begin
      word_o = NOP_WORD;
    end
    legal_o = fields_ok_s;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs field tuples into instruction words, writes them sequentially to memory, then pads with NOPs.
// Optional macro FIELD_CHECK_EN enables per-tuple re-decode checks in the packer.
module instr_encoder_loader
  import instr_fmt_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PAD_NOPS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_last_i,
  input  logic [1:0]          in_format_i,
  input  logic [REG_W-1:0]    in_rsrc1_i,
  input  logic [REG_W-1:0]    in_rsrc2_i,
  input  logic [REG_W-1:0]    in_rdst_i,
  input  logic [OPC_A_W-1:0]  in_opcode_i,
  input  logic [IMM_C_W-1:0]  in_imm_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [WORD_W-1:0]   mem_wdata_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W:0]     word_count_o
);

  localparam int PAD_CNT_W = $clog2(PAD_NOPS + 2);
  localparam logic [PAD_CNT_W-1:0] PAD_LAST = PAD_CNT_W'(PAD_NOPS - 1);
  localparam logic [PAD_CNT_W-1:0] PAD_ONE  = PAD_CNT_W'(1'b1);
  localparam logic [ADDR_W-1:0]    ADDR_ONE = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0]    ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]      CNT_ONE  = (ADDR_W + 1)'(1'b1);

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [PAD_CNT_W-1:0] pad_q, pad_d;
  logic                 at_end_q, at_end_d;
  logic                 err_q, err_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    maddr_q, maddr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 issue_s;
  logic [WORD_W-1:0]    issue_word_s;
  instr_fields_t        fields_s;
  logic [WORD_W-1:0]    pack_word_s;
  logic                 pack_legal_s;

  assign fields_s = '{fmt:    in_format_i,
                      rsrc1:  in_rsrc1_i,
                      rsrc2:  in_rsrc2_i,
                      rdst:   in_rdst_i,
                      opcode: in_opcode_i,
                      imm:    in_imm_i};

  instr_word_pack u_pack (
    .fields_i (fields_s),
    .word_o   (pack_word_s),
    .legal_o  (pack_legal_s)
  );

  // Session FSM and write issue; at_end_q marks that the top address has been written.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    pad_d        = pad_q;
    at_end_d     = at_end_q;
    err_d        = err_q;
    we_d         = 1'b0;
    maddr_d      = maddr_q;
    wdata_d      = wdata_q;
    issue_s      = 1'b0;
    issue_word_s = NOP_WORD;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_RUN;
          addr_d   = base_addr_i;
          count_d  = {(ADDR_W + 1){1'b0}};
          pad_d    = {PAD_CNT_W{1'b0}};
          at_end_d = 1'b0;
          err_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_valid_i) begin
          if (at_end_q) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            issue_s      = 1'b1;
            issue_word_s = pack_word_s;
            if (!pack_legal_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (in_last_i) begin
              state_d = (PAD_NOPS == 0) ? ST_DONE : ST_PAD;
            end else begin
              state_d = ST_RUN;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAD: begin
        if (at_end_q) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          issue_s      = 1'b1;
          issue_word_s = NOP_WORD;
          pad_d        = pad_q + PAD_ONE;
          state_d      = (pad_q == PAD_LAST) ? ST_DONE : ST_PAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue_s) begin
      we_d     = 1'b1;
      maddr_d  = addr_q;
      wdata_d  = issue_word_s;
      addr_d   = addr_q + ADDR_ONE;
      count_d  = count_q + CNT_ONE;
      at_end_d = (addr_q == ADDR_MAX);
    end else begin
      we_d = 1'b0;
    end
  end

  assign done_d  = (state_q == ST_DONE);
  assign busy_d  = (state_d != ST_IDLE);
  assign ready_d = (state_d == ST_RUN);

  // State and registered outputs; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      count_q  <= {(ADDR_W + 1){1'b0}};
      pad_q    <= {PAD_CNT_W{1'b0}};
      at_end_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= {ADDR_W{1'b0}};
      wdata_q  <= {WORD_W{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      pad_q    <= pad_d;
      at_end_q <= at_end_d;
      err_q    <= err_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready_o   = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = count_q;

endmodule
